// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared state encoding and shift-direction constants for serial_word_receiver.
`default_nettype none

package serial_rx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  localparam logic DIR_TOWARD0  = 1'b0;
  localparam logic DIR_TOWARD_N = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial bit input, word output buffer handshake and status flags.
`default_nettype none

interface serial_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             SerIn;
  logic             SerValid;
  logic             Start;
  logic             Dir;
  logic [0:WIDTH-1] Q;
  logic             QValid;
  logic             QReady;
  logic             Busy;
  logic             FrameErr;
  logic             Overrun;
  logic             ClearOvr;

  modport master (
    output SerIn, SerValid, Start, Dir, QReady, ClearOvr,
    input  Q, QValid, Busy, FrameErr, Overrun
  );

  modport slave (
    input  SerIn, SerValid, Start, Dir, QReady, ClearOvr,
    output Q, QValid, Busy, FrameErr, Overrun
  );
endinterface

`default_nettype wire

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: WIDTH-bit bidirectional shift register with synchronous clear.
`default_nettype none

module rx_shift_reg
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic             Clock,
  input  wire logic             Resetn,
  input  wire logic             en,
  input  wire logic             clr,
  input  wire logic             dir,
  input  wire logic             din,
  output logic      [0:WIDTH-1] word
);

  logic [0:WIDTH-1] word_q;
  logic [0:WIDTH-1] word_d;
  logic [0:WIDTH-1] base;

  always_comb begin
    base   = clr ? '0 : word_q;
    word_d = base;
    if (en) begin
      if (dir == DIR_TOWARD_N) begin
        word_d = {din, base[0:WIDTH-2]};
      end else begin
        word_d = {base[1:WIDTH-1], din};
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Exposes the value including this cycle's bit so a finished frame is captured on its last edge.
  assign word = word_d;

endmodule

`default_nettype wire

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: frames Start-qualified serial bits into WIDTH-bit words and
// presents them through a single-entry valid/ready output buffer.
`default_nettype none

module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic               Clock,
  input  wire logic               Resetn,
  serial_word_receiver_if.slave   bus
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ferr_q, ferr_d;
  logic [0:WIDTH-1] q_q, q_d;
  logic             qv_q, qv_d;
  logic             ovr_q, ovr_d;

  logic             sr_en;
  logic             sr_clr;
  logic             sr_dir;
  logic             frame_done;
  logic [0:WIDTH-1] sr_word;

  rx_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (sr_en),
    .clr    (sr_clr),
    .dir    (sr_dir),
    .din    (bus.SerIn),
    .word   (sr_word)
  );

  // Framing FSM; a Start always restarts, including on what would have been the last bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    ferr_d     = 1'b0;
    sr_en      = 1'b0;
    sr_clr     = 1'b0;
    sr_dir     = dir_q;
    frame_done = 1'b0;
    if (bus.SerValid) begin
      if (bus.Start) begin
        sr_en   = 1'b1;
        sr_clr  = 1'b1;
        sr_dir  = bus.Dir;
        dir_d   = bus.Dir;
        cnt_d   = CNT_ONE;
        state_d = ST_SHIFT;
        ferr_d  = (state_q == ST_SHIFT);
      end else if (state_q == ST_SHIFT) begin
        sr_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Output buffer: a completed word is accepted if the slot is free or drained at the same edge.
  always_comb begin
    q_d   = q_q;
    qv_d  = qv_q;
    ovr_d = ovr_q;
    if (bus.ClearOvr) begin
      ovr_d = 1'b0;
    end
    if (frame_done) begin
      if (!qv_q || bus.QReady) begin
        q_d  = sr_word;
        qv_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (qv_q && bus.QReady) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_TOWARD0;
      ferr_q  <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ferr_q  <= ferr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.QValid   = qv_q;
  assign bus.Busy     = (state_q == ST_SHIFT);
  assign bus.FrameErr = ferr_q;
  assign bus.Overrun  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed and randomized checks against a frame-level reference model.
`default_nettype none

module tb_serial_word_receiver;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(W)) bus ();

  serial_word_receiver #(
    .WIDTH (W)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int ferr_seen = 0;

  // Reference model: a frame is a list of received bits; the word is assembled only when complete.
  bit           m_busy;
  int           m_cnt;
  bit           m_dir;
  bit           m_bits [W];
  logic [0:W-1] m_q;
  bit           m_qv;
  bit           m_ferr;
  bit           m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cnt  = 0;
    m_dir  = 1'b0;
    m_q    = '0;
    m_qv   = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
  endtask

  task automatic check_outputs();
    chk("q",        32'(bus.Q),        32'(m_q));
    chk("qvalid",   32'(bus.QValid),   32'(m_qv));
    chk("busy",     32'(bus.Busy),     32'(m_busy));
    chk("frameerr", 32'(bus.FrameErr), 32'(m_ferr));
    chk("overrun",  32'(bus.Overrun),  32'(m_ovr));
  endtask

  task automatic step();
    bit           busy_n;
    int           cnt_n;
    bit           dir_n;
    bit           bits_n [W];
    logic [0:W-1] q_n;
    logic [0:W-1] word;
    bit           qv_n;
    bit           ferr_n;
    bit           ovr_set;
    bit           done;
    busy_n  = m_busy;
    cnt_n   = m_cnt;
    dir_n   = m_dir;
    bits_n  = m_bits;
    q_n     = m_q;
    qv_n    = m_qv;
    ferr_n  = 1'b0;
    ovr_set = 1'b0;
    done    = 1'b0;
    word    = '0;
    if (bus.SerValid) begin
      if (bus.Start) begin
        ferr_n    = m_busy;
        bits_n[0] = bus.SerIn;
        cnt_n     = 1;
        dir_n     = bus.Dir;
        busy_n    = 1'b1;
      end else if (m_busy) begin
        bits_n[m_cnt] = bus.SerIn;
        cnt_n         = m_cnt + 1;
        if (cnt_n == W) begin
          done   = 1'b1;
          busy_n = 1'b0;
          cnt_n  = 0;
          for (int i = 0; i < W; i++) word[i] = m_dir ? bits_n[W-1-i] : bits_n[i];
        end
      end
    end
    if (done) begin
      if (!m_qv || bus.QReady) begin
        q_n  = word;
        qv_n = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (m_qv && bus.QReady) begin
      qv_n = 1'b0;
    end
    @(posedge clk);
    #1;
    m_busy = busy_n;
    m_cnt  = cnt_n;
    m_dir  = dir_n;
    m_bits = bits_n;
    m_q    = q_n;
    m_qv   = qv_n;
    m_ferr = ferr_n;
    m_ovr  = ovr_set ? 1'b1 : (bus.ClearOvr ? 1'b0 : m_ovr);
    if (bus.FrameErr) ferr_seen++;
    check_outputs();
  endtask

  task automatic send(input logic din, input logic start, input logic dir);
    bus.SerValid = 1'b1;
    bus.SerIn    = din;
    bus.Start    = start;
    bus.Dir      = dir;
    step();
    bus.SerValid = 1'b0;
    bus.Start    = 1'b0;
  endtask

  task automatic gap();
    bus.SerValid = 1'b0;
    bus.Start    = 1'b0;
    step();
  endtask

  task automatic send_frame(input logic [0:W-1] bits, input logic dir);
    for (int i = 0; i < W; i++) send(bits[i], (i == 0), dir);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SerIn    = 1'b0;
    bus.SerValid = 1'b0;
    bus.Start    = 1'b0;
    bus.Dir      = 1'b0;
    bus.QReady   = 1'b0;
    bus.ClearOvr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-frame discards the partial frame; a following bit without Start is ignored.
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t1_busy_pre", 32'(bus.Busy), 32'd1);
    apply_reset(2);
    chk("t1_q_rst", 32'(bus.Q), 32'd0);
    send(1'b1, 1'b0, 1'b0);
    chk("t1_busy_ign", 32'(bus.Busy), 32'd0);

    // Dir=0, back-to-back bits.
    send(1'b1, 1'b1, 1'b0);
    chk("t2_busy_b2", 32'(bus.Busy), 32'd1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    chk("t2_qv_pre", 32'(bus.QValid), 32'd0);
    send(1'b1, 1'b0, 1'b0);
    chk("t2_q", 32'(bus.Q), 32'b1011);
    chk("t2_qv", 32'(bus.QValid), 32'd1);
    chk("t2_busy_end", 32'(bus.Busy), 32'd0);
    bus.QReady = 1'b1;
    gap();
    bus.QReady = 1'b0;

    // Dir=1 with gaps; Dir changes mid-frame are ignored.
    send(1'b1, 1'b1, 1'b1);
    gap();
    send(1'b0, 1'b0, 1'b0);
    gap();
    send(1'b1, 1'b0, 1'b1);
    gap();
    send(1'b1, 1'b0, 1'b0);
    chk("t3_q", 32'(bus.Q), 32'b1101);
    chk("t3_qv", 32'(bus.QValid), 32'd1);
    bus.QReady = 1'b1;
    gap();
    bus.QReady = 1'b0;

    // Overrun when buffer full, then clear.
    send_frame(4'b1011, 1'b0);
    send_frame(4'b0110, 1'b0);
    chk("t4_q", 32'(bus.Q), 32'b1011);
    chk("t4_ovr", 32'(bus.Overrun), 32'd1);
    bus.ClearOvr = 1'b1;
    gap();
    bus.ClearOvr = 1'b0;
    chk("t4_ovr_clr", 32'(bus.Overrun), 32'd0);
    bus.QReady = 1'b1;
    gap();
    bus.QReady = 1'b0;
    chk("t4_qv_drain", 32'(bus.QValid), 32'd0);

    // Drain and completion on the same edge.
    send_frame(4'b1011, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    bus.QReady = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    bus.QReady = 1'b0;
    chk("t5_q", 32'(bus.Q), 32'b0110);
    chk("t5_qv", 32'(bus.QValid), 32'd1);
    chk("t5_ovr", 32'(bus.Overrun), 32'd0);
    bus.QReady = 1'b1;
    gap();
    bus.QReady = 1'b0;

    // Restart mid-frame.
    ferr_seen = 0;
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    gap();
    chk("t6_ferr_cnt", 32'(ferr_seen), 32'd1);
    chk("t6_q", 32'(bus.Q), 32'b0010);

    // Start on what would be the last bit restarts instead of completing.
    bus.QReady = 1'b1;
    gap();
    bus.QReady = 1'b0;
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("t7_qv", 32'(bus.QValid), 32'd0);
    chk("t7_ferr", 32'(bus.FrameErr), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(399, 0) == 0) begin
        apply_reset(1 + int'($urandom_range(2, 0)));
      end
      bus.SerValid = ($urandom_range(9, 0) < 7);
      bus.Start    = ($urandom_range(7, 0) == 0);
      bus.SerIn    = 1'($urandom);
      bus.Dir      = 1'($urandom);
      bus.QReady   = 1'($urandom);
      bus.ClearOvr = ($urandom_range(19, 0) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
